// File: rtl/accel_burst_reader.sv
// accel_burst_reader
//  SPI mode-3 master for a 3-axis accelerometer. After reset it writes the
//  power-control and data-format registers once, then issues a multi-byte
//  burst read of N_AXES axes every SAMPLE_TICKS cycles and presents all axes
//  together as one frame, flagged by a single-cycle osync strobe.
// Ports
//  sys_clock, reset     clock, asynchronous active-low reset
//  enable               run init/bursts; dropping it stops after the current transaction
//  MOSI/MISO/SCL/CS     SPI bus (SCL idles high, CS active low)
//  osync, accel_data    frame strobe and N_AXES signed samples, X in the LSBs
//  init_done, busy      init writes completed / bus or inter-transaction gap active
module accel_burst_reader #(
   parameter int         CLK_DIV      = 8,
   parameter int         N_AXES       = 3,
   parameter int         DATA_WIDTH   = 16,
   parameter int         SAMPLE_TICKS = 100000,
   parameter logic [7:0] START_REG    = 8'h32,
   parameter logic [7:0] PWR_CTL_VAL  = 8'h08,
   parameter logic [7:0] FMT_VAL      = 8'h00
) (
   input  logic                         sys_clock,
   input  logic                         reset,
   input  logic                         enable,
   output logic                         MOSI,
   input  logic                         MISO,
   output logic                         SCL,
   output logic                         CS,
   output logic                         osync,
   output logic [N_AXES*DATA_WIDTH-1:0] accel_data,
   output logic                         init_done,
   output logic                         busy
);
   localparam int TXW = 8 * (1 + 2 * N_AXES);   // command byte + 2 bytes per axis
   localparam int RXW = 16 * N_AXES;
   localparam int CW  = $clog2(2 * CLK_DIV);
   localparam int GW  = $clog2(2 * CLK_DIV + 1);
   localparam int BW  = $clog2(TXW);
   localparam int TW  = $clog2(SAMPLE_TICKS);

   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] HALF      = CW'(CLK_DIV);
   localparam logic [CW-1:0] BIT_LAST  = CW'(2 * CLK_DIV - 1);
   localparam logic [GW-1:0] GAP_LEN   = GW'(2 * CLK_DIV);
   localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_TICKS - 1);
   localparam logic [BW-1:0] INIT_LAST = BW'(15);
   localparam logic [BW-1:0] BURST_LAST = BW'(TXW - 1);
   localparam logic [7:0]    CMD       = {2'b11, START_REG[5:0]};   // read, multi-byte

   typedef enum logic [2:0] {S_IDLE, S_INIT_PWR, S_INIT_FMT, S_WAIT, S_BURST, S_EMIT} state_t;
   typedef enum logic [1:0] {P_START, P_SETUP, P_SHIFT, P_HOLD} phase_t;

   state_t               state;
   phase_t               phase;
   logic [CW-1:0]        cnt;
   logic [BW-1:0]        bit_idx;
   logic [GW-1:0]        gap;
   logic [TW-1:0]        timer;
   logic [TXW-1:0]       tx;
   logic [RXW-1:0]       rx;
   logic [N_AXES*DATA_WIDTH-1:0] frame;

   // Received bytes arrive X0,X1,Y0,Y1,... so X0 sits highest in rx.
   for (genvar a = 0; a < N_AXES; a++) begin : g_axis
      logic [15:0] raw;
      assign raw = {rx[8*(2*N_AXES-2-2*a) +: 8], rx[8*(2*N_AXES-1-2*a) +: 8]};
      if (DATA_WIDTH == 16) begin : g_full
         assign frame[a*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(raw);
      end else begin : g_narrow
         // 10-bit right-justified sample: keep the top 8 of the 10 valid bits.
         logic unused_hi;
         assign unused_hi = ^{raw[15:10], raw[1:0]};
         assign frame[a*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(raw[9:2]);
      end
   end

   assign busy = ~CS | (gap != '0);

   always_ff @(posedge sys_clock or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         phase      <= P_START;
         cnt        <= '0;
         bit_idx    <= '0;
         gap        <= '0;
         timer      <= '0;
         tx         <= '0;
         rx         <= '0;
         CS         <= 1'b1;
         SCL        <= 1'b1;
         MOSI       <= 1'b0;
         osync      <= 1'b0;
         accel_data <= '0;
         init_done  <= 1'b0;
      end else begin
         osync <= 1'b0;
         if (gap != '0) gap <= gap - 1'b1;
         case (state)
            S_IDLE: if (enable) begin
               phase <= P_START;
               timer <= '0;
               state <= init_done ? S_WAIT : S_INIT_PWR;
            end
            S_WAIT: begin
               if (!enable) state <= S_IDLE;
               else if (timer == TICK_LAST) begin
                  timer <= '0;
                  phase <= P_START;
                  state <= S_BURST;
               end else timer <= timer + 1'b1;
            end
            S_EMIT: begin
               osync      <= 1'b1;
               accel_data <= frame;
               timer      <= timer + 1'b1;
               state      <= enable ? S_WAIT : S_IDLE;
            end
            default: begin   // INIT_PWR, INIT_FMT, BURST: one SPI transaction each
               if (state == S_BURST) timer <= timer + 1'b1;
               case (phase)
                  P_START: begin
                     if (!enable) state <= S_IDLE;
                     else if (gap == '0) begin   // CS high long enough since last rise
                        CS      <= 1'b0;
                        cnt     <= '0;
                        bit_idx <= '0;
                        phase   <= P_SETUP;
                        if (state == S_BURST)        tx <= {CMD, {(TXW-8){1'b0}}};
                        else if (state == S_INIT_PWR) tx <= {8'h2D, PWR_CTL_VAL, {(TXW-16){1'b0}}};
                        else                          tx <= {8'h31, FMT_VAL, {(TXW-16){1'b0}}};
                     end
                  end
                  P_SETUP: begin
                     if (cnt == HALF_LAST) begin
                        cnt   <= '0;
                        phase <= P_SHIFT;
                     end else cnt <= cnt + 1'b1;
                  end
                  P_SHIFT: begin
                     // First half of each bit SCL low (MOSI changes), second half high (MISO sampled).
                     if (cnt == '0) begin
                        SCL  <= 1'b0;
                        MOSI <= tx[TXW-1];
                        tx   <= {tx[TXW-2:0], 1'b0};
                     end
                     if (cnt == HALF) begin
                        SCL <= 1'b1;
                        rx  <= {rx[RXW-2:0], MISO};
                     end
                     if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (bit_idx == ((state == S_BURST) ? BURST_LAST : INIT_LAST)) phase <= P_HOLD;
                        else bit_idx <= bit_idx + 1'b1;
                     end else cnt <= cnt + 1'b1;
                  end
                  P_HOLD: begin
                     if (cnt == HALF_LAST) begin
                        CS    <= 1'b1;
                        MOSI  <= 1'b0;
                        gap   <= GAP_LEN;
                        cnt   <= '0;
                        phase <= P_START;
                        if (state == S_INIT_PWR) state <= S_INIT_FMT;
                        else if (state == S_INIT_FMT) begin
                           init_done <= 1'b1;
                           timer     <= '0;
                           state     <= enable ? S_WAIT : S_IDLE;
                        end else state <= S_EMIT;
                     end else cnt <= cnt + 1'b1;
                  end
                  default: phase <= P_START;
               endcase
            end
         endcase
      end
   end
endmodule

// File: tb/tb_accel_burst_reader.sv
// tb_accel_burst_reader
//  Directed bench: dut_a (3 axes, 16-bit, 2000-cycle period) covers init,
//  bursts, period, enable drop and mid-burst reset; dut_b (1 axis, 8-bit)
//  covers the narrowed output. A per-DUT sensor model answers on MISO and
//  records each SPI transaction.
module tb_accel_burst_reader;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, en_a, en_b;
   logic        mosi_a, miso_a, scl_a, cs_a, osync_a, idone_a, busy_a;
   logic        mosi_b, miso_b, scl_b, cs_b, osync_b, idone_b, busy_b;
   logic [47:0] data_a;
   logic [7:0]  data_b;
   logic [47:0] resp_a = '0;
   logic [15:0] resp_b = '0;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   accel_burst_reader #(.CLK_DIV(4), .N_AXES(3), .DATA_WIDTH(16), .SAMPLE_TICKS(2000)) dut_a (
      .sys_clock(clk), .reset(rst_n), .enable(en_a), .MOSI(mosi_a), .MISO(miso_a), .SCL(scl_a),
      .CS(cs_a), .osync(osync_a), .accel_data(data_a), .init_done(idone_a), .busy(busy_a));

   accel_burst_reader #(.CLK_DIV(4), .N_AXES(1), .DATA_WIDTH(8), .SAMPLE_TICKS(1000)) dut_b (
      .sys_clock(clk), .reset(rst_n), .enable(en_b), .MOSI(mosi_b), .MISO(miso_b), .SCL(scl_b),
      .CS(cs_b), .osync(osync_b), .accel_data(data_b), .init_done(idone_b), .busy(busy_b));

   always @(negedge clk) cyc = cyc + 1;

   // Sensor model + transaction recorder, sampled on the falling system edge.
   for (genvar g = 0; g < 2; g++) begin : mon
      logic        cs_w, scl_w, mosi_w, osync_w, idone_w;
      logic        prev_cs = 1'b1, prev_scl = 1'b1, miso_r = 1'b0, last_idone = 1'b0;
      logic [55:0] msr = '0;
      logic [63:0] mosi_sr = '0, last_mosi = '0;
      int          bits = 0, falls = 0, last_bits = 0, last_falls = 0;
      int          ntxn = 0, nfall = 0, osync_n = 0, scl_total = 0;
      int          last_fall_t = 0, prev_fall_t = 0;
      assign cs_w    = (g == 0) ? cs_a    : cs_b;
      assign scl_w   = (g == 0) ? scl_a   : scl_b;
      assign mosi_w  = (g == 0) ? mosi_a  : mosi_b;
      assign osync_w = (g == 0) ? osync_a : osync_b;
      assign idone_w = (g == 0) ? idone_a : idone_b;
      always @(negedge clk) begin
         if (prev_cs && !cs_w) begin
            prev_fall_t = last_fall_t;
            last_fall_t = cyc;
            nfall++;
            bits = 0;
            falls = 0;
            mosi_sr = '0;
            msr = (g == 0) ? {8'h00, resp_a} : {8'h00, resp_b, 32'h0};
         end
         if (prev_scl && !scl_w) begin
            scl_total++;
            if (!cs_w) begin
               falls++;
               miso_r = msr[55];
               msr = {msr[54:0], 1'b0};
            end
         end
         if (!prev_scl && scl_w && !cs_w) begin
            mosi_sr = {mosi_sr[62:0], mosi_w};
            bits++;
         end
         if (!prev_cs && cs_w) begin
            last_mosi = mosi_sr;
            last_bits = bits;
            last_falls = falls;
            last_idone = idone_w;
            ntxn++;
         end
         if (osync_w) osync_n++;
         prev_cs = cs_w;
         prev_scl = scl_w;
      end
   end
   assign miso_a = mon[0].miso_r;
   assign miso_b = mon[1].miso_r;

   function automatic int evt(input int which);
      case (which)
         0:       return mon[0].ntxn;
         1:       return mon[0].nfall;
         2:       return mon[0].osync_n;
         default: return mon[1].osync_n;
      endcase
   endfunction

   // Bounded wait for a recorder counter to reach target.
   task automatic wait_evt(input int which, input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (evt(which) >= target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0;
      #30;
      checks++; if (cs_a !== 1'b1) begin errors++; $display("FAIL reset_cs got %b want 1", cs_a); end
      checks++; if (scl_a !== 1'b1) begin errors++; $display("FAIL reset_scl got %b want 1", scl_a); end
      checks++; if (mosi_a !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", mosi_a); end
      checks++; if (osync_a !== 1'b0) begin errors++; $display("FAIL reset_osync got %b want 0", osync_a); end
      checks++; if (data_a !== 48'h0) begin errors++; $display("FAIL reset_data got %h want 0", data_a); end
      checks++; if (idone_a !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b want 0", idone_a); end
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_a); end
      checks++; if (cs_b !== 1'b1 || data_b !== 8'h0) begin errors++; $display("FAIL reset_b got cs=%b data=%h want 1/00", cs_b, data_b); end
   endtask

   task automatic test_init;
      bit ok;
      @(negedge clk); rst_n = 1'b1; en_a = 1'b1;
      wait_evt(0, 1, 1000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL init_pwr_timeout got none want txn"); end
      checks++; if (mon[0].last_mosi[15:0] !== 16'h2D08) begin errors++; $display("FAIL init_pwr_mosi got %h want 2d08", mon[0].last_mosi[15:0]); end
      checks++; if (mon[0].last_falls != 16 || mon[0].last_bits != 16) begin errors++; $display("FAIL init_pwr_scl got falls=%0d bits=%0d want 16/16", mon[0].last_falls, mon[0].last_bits); end
      checks++; if (mon[0].last_idone !== 1'b0) begin errors++; $display("FAIL init_done_early got %b want 0", mon[0].last_idone); end
      wait_evt(0, 2, 1000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL init_fmt_timeout got none want txn"); end
      checks++; if (mon[0].last_mosi[15:0] !== 16'h3100) begin errors++; $display("FAIL init_fmt_mosi got %h want 3100", mon[0].last_mosi[15:0]); end
      checks++; if (mon[0].last_falls != 16) begin errors++; $display("FAIL init_fmt_scl got %0d want 16", mon[0].last_falls); end
      checks++; if (mon[0].last_idone !== 1'b1 || idone_a !== 1'b1) begin errors++; $display("FAIL init_done got %b/%b want 1", mon[0].last_idone, idone_a); end
   endtask

   task automatic test_burst;
      bit ok;
      int o0;
      resp_a = 48'h10_00_F0_FF_00_01;
      o0 = mon[0].osync_n;
      wait_evt(2, o0 + 1, 3000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL burst_timeout got no osync want 1"); end
      checks++; if (mon[0].last_bits != 56 || mon[0].last_falls != 56) begin errors++; $display("FAIL burst_scl got bits=%0d falls=%0d want 56", mon[0].last_bits, mon[0].last_falls); end
      checks++; if (mon[0].last_mosi[55:0] !== {8'hF2, 48'h0}) begin errors++; $display("FAIL burst_mosi got %h want f2 then zeros", mon[0].last_mosi[55:0]); end
      checks++; if (data_a !== 48'h0100_FFF0_0010) begin errors++; $display("FAIL burst_data got %h want 0100fff00010", data_a); end
      wait_cyc(100);
      checks++; if (mon[0].osync_n != o0 + 1) begin errors++; $display("FAIL osync_width got %0d want %0d", mon[0].osync_n, o0 + 1); end
      checks++; if (data_a !== 48'h0100_FFF0_0010) begin errors++; $display("FAIL data_hold got %h want 0100fff00010", data_a); end
   endtask

   task automatic test_period;
      bit ok;
      int o0, f0;
      resp_a = 48'hFF_7F_00_80_AA_55;
      o0 = mon[0].osync_n;
      f0 = mon[0].nfall;
      wait_evt(2, o0 + 2, 4500, ok);
      checks++; if (!ok) begin errors++; $display("FAIL period_timeout got %0d want %0d", mon[0].osync_n, o0 + 2); end
      checks++; if (mon[0].last_fall_t - mon[0].prev_fall_t != 2000) begin errors++; $display("FAIL period got %0d want 2000", mon[0].last_fall_t - mon[0].prev_fall_t); end
      checks++; if (mon[0].nfall != f0 + 2) begin errors++; $display("FAIL period_cs_falls got %0d want %0d", mon[0].nfall, f0 + 2); end
      checks++; if (data_a !== 48'h55AA_8000_7FFF) begin errors++; $display("FAIL period_data got %h want 55aa80007fff", data_a); end
   endtask

   task automatic test_enable_drop;
      bit ok;
      int o0, f0, s0;
      o0 = mon[0].osync_n;
      f0 = mon[0].nfall;
      wait_evt(1, f0 + 1, 2500, ok);
      wait_cyc(100);
      en_a = 1'b0;
      wait_evt(2, o0 + 1, 1000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL drop_no_emit got none want osync"); end
      s0 = mon[0].scl_total;
      wait_cyc(3000);
      checks++; if (mon[0].osync_n != o0 + 1) begin errors++; $display("FAIL drop_osync got %0d want %0d", mon[0].osync_n, o0 + 1); end
      checks++; if (mon[0].scl_total != s0 || mon[0].nfall != f0 + 1) begin errors++; $display("FAIL drop_activity got scl=%0d falls=%0d want %0d/%0d", mon[0].scl_total, mon[0].nfall, s0, f0 + 1); end
      checks++; if (cs_a !== 1'b1 || busy_a !== 1'b0) begin errors++; $display("FAIL drop_idle got cs=%b busy=%b want 1/0", cs_a, busy_a); end
      checks++; if (data_a !== 48'h55AA_8000_7FFF) begin errors++; $display("FAIL drop_data got %h want 55aa80007fff", data_a); end
   endtask

   task automatic test_narrow;
      bit ok;
      resp_b = 16'hE0_0F;
      en_b = 1'b1;
      wait_evt(3, 1, 3000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL narrow_timeout got no osync want 1"); end
      checks++; if (mon[1].last_bits != 24 || mon[1].last_falls != 24) begin errors++; $display("FAIL narrow_scl got bits=%0d falls=%0d want 24", mon[1].last_bits, mon[1].last_falls); end
      checks++; if (mon[1].last_mosi[23:16] !== 8'hF2) begin errors++; $display("FAIL narrow_cmd got %h want f2", mon[1].last_mosi[23:16]); end
      checks++; if (data_b !== 8'hF8) begin errors++; $display("FAIL narrow_data got %h want f8", data_b); end
      en_b = 1'b0;
   endtask

   task automatic test_reset_mid;
      bit ok;
      int o0, n0, f0, o1, n1;
      o0 = mon[0].osync_n;
      n0 = mon[0].ntxn;
      en_a = 1'b1;
      wait_evt(2, o0 + 1, 2600, ok);
      checks++; if (!ok) begin errors++; $display("FAIL reenable_timeout got no osync want 1"); end
      checks++; if (mon[0].ntxn != n0 + 1 || mon[0].last_bits != 56) begin errors++; $display("FAIL reenable_reinit got txns=%0d bits=%0d want %0d/56", mon[0].ntxn - n0, mon[0].last_bits, 1); end
      f0 = mon[0].nfall;
      wait_evt(1, f0 + 1, 2500, ok);
      wait_cyc(150);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (cs_a !== 1'b1 || scl_a !== 1'b1 || mosi_a !== 1'b0) begin errors++; $display("FAIL abort_bus got cs=%b scl=%b mosi=%b want 1/1/0", cs_a, scl_a, mosi_a); end
      checks++; if (data_a !== 48'h0 || idone_a !== 1'b0 || osync_a !== 1'b0) begin errors++; $display("FAIL abort_state got data=%h done=%b osync=%b want 0", data_a, idone_a, osync_a); end
      o1 = mon[0].osync_n;
      wait_cyc(10);
      rst_n = 1'b1;
      n1 = mon[0].ntxn;
      wait_evt(0, n1 + 1, 1000, ok);
      checks++; if (!ok || mon[0].last_mosi[15:0] !== 16'h2D08) begin errors++; $display("FAIL reinit_pwr got %h want 2d08", mon[0].last_mosi[15:0]); end
      wait_evt(0, n1 + 2, 1000, ok);
      checks++; if (!ok || mon[0].last_mosi[15:0] !== 16'h3100 || idone_a !== 1'b1) begin errors++; $display("FAIL reinit_fmt got %h done=%b want 3100/1", mon[0].last_mosi[15:0], idone_a); end
      checks++; if (mon[0].osync_n != o1) begin errors++; $display("FAIL abort_osync got %0d want %0d", mon[0].osync_n, o1); end
   endtask

   initial begin
      test_reset;
      test_init;
      test_burst;
      test_period;
      test_enable_drop;
      test_narrow;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1);
   end
endmodule
